// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase codes,
// lamp one-hot encodings and a small elaboration helper.
package traffic_pkg;

  // Phase codes. Code 7 is never entered by normal sequencing; it exists
  // so that a corrupted register has a name and a defined recovery path.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    PH_UNUSED = 3'd7
  } phase_e;

  // Lamp encodings, one-hot {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Largest of four durations; sizes the phase timer check.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// phase_timer: up-counter that clears to zero on clr and otherwise
// counts up until it reaches sat_at, where it holds.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] sat_at,
  output logic [W-1:0] count
);

  // Count register: clear has priority over counting; hold at sat_at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count < sat_at) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road intersection controller.
// NS holds green (minimum GREEN_CYCLES) until an EW car or a pedestrian
// request is pending, then sequences yellow -> all-red -> EW green ->
// EW yellow -> all-red -> back to NS green.
// Optional feature macro: TRAFFIC_PED_WALK_EN inserts a PED_WALK phase
// after the first all-red when a pedestrian request is pending.
// All outputs come from registered state only; the phase output is the
// FSM state itself.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 6,
  parameter int TIMER_WIDTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic       walk,
  output logic       ped_pending
);

  localparam int MAX_DUR = max4(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES);

  // The timer must be able to hold the last cycle index of the longest phase.
  if ((MAX_DUR - 1) >= (1 << TIMER_WIDTH)) begin : g_bad_timer_width
    $error("traffic_phase_ctrl: TIMER_WIDTH too small for the longest phase");
  end
  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || ALLRED_CYCLES < 1 || WALK_CYCLES < 1)
  begin : g_bad_duration
    $error("traffic_phase_ctrl: every phase duration must be at least 1");
  end

  // Last timer value of each phase (duration - 1).
  localparam logic [TIMER_WIDTH-1:0] G_LAST = TIMER_WIDTH'(GREEN_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] Y_LAST = TIMER_WIDTH'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] A_LAST = TIMER_WIDTH'(ALLRED_CYCLES - 1);
`ifdef TRAFFIC_PED_WALK_EN
  localparam logic [TIMER_WIDTH-1:0] W_LAST = TIMER_WIDTH'(WALK_CYCLES - 1);
`endif

  phase_e                 phase_q;
  phase_e                 phase_d;
  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] sat_at;
  logic                   phase_change;
  logic                   ped_pending_q;
  logic                   ped_clr;

  // Phase timer: restarts at 0 on every phase change; saturates at sat_at,
  // which only matters while NS green is held waiting for demand.
  phase_timer #(
    .W (TIMER_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (phase_change),
    .sat_at (sat_at),
    .count  (timer)
  );

  // Phase state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= NS_GREEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next-phase logic: fixed phases advance when the timer reaches their last
  // cycle; NS green additionally waits for an EW car or pending pedestrian.
  always_comb begin
    phase_d = phase_q;
    sat_at  = '1;
    case (phase_q)
      NS_GREEN: begin
        sat_at = G_LAST;
        if (timer >= G_LAST && (ew_car || ped_pending_q)) phase_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        sat_at = Y_LAST;
        if (timer >= Y_LAST) phase_d = ALL_RED_1;
      end
      ALL_RED_1: begin
        sat_at = A_LAST;
        if (timer >= A_LAST) begin
`ifdef TRAFFIC_PED_WALK_EN
          phase_d = ped_pending_q ? PED_WALK : EW_GREEN;
`else
          phase_d = EW_GREEN;
`endif
        end
      end
      EW_GREEN: begin
        sat_at = G_LAST;
        if (timer >= G_LAST) phase_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        sat_at = Y_LAST;
        if (timer >= Y_LAST) phase_d = ALL_RED_2;
      end
      ALL_RED_2: begin
        sat_at = A_LAST;
        if (timer >= A_LAST) phase_d = NS_GREEN;
      end
      PED_WALK: begin
`ifdef TRAFFIC_PED_WALK_EN
        sat_at = W_LAST;
        if (timer >= W_LAST) phase_d = EW_GREEN;
`else
        // Unreachable without the walk feature; recover to a safe phase.
        phase_d = NS_GREEN;
`endif
      end
      default: begin
        phase_d = NS_GREEN;
      end
    endcase
    phase_change = (phase_d != phase_q);
  end

  // Pedestrian request clear point: served once walk ends (feature on) or
  // once EW green begins (feature off).
  always_comb begin
`ifdef TRAFFIC_PED_WALK_EN
    ped_clr = (phase_q == PED_WALK) && phase_change;
`else
    ped_clr = (phase_d == EW_GREEN) && phase_change;
`endif
  end

  // Latched pedestrian request; a new press on the clearing edge wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pending_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_req | (ped_pending_q & ~ped_clr);
    end
  end

  // Lamp decode from the registered phase; unlisted phases show all red.
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (phase_q)
      NS_GREEN:  ns_light = LAMP_GRN;
      NS_YELLOW: ns_light = LAMP_YEL;
      EW_GREEN:  ew_light = LAMP_GRN;
      EW_YELLOW: ew_light = LAMP_YEL;
      default:   ;
    endcase
  end

`ifdef TRAFFIC_PED_WALK_EN
  assign walk = (phase_q == PED_WALK);
`else
  assign walk = 1'b0;
`endif

  assign phase       = phase_q;
  assign ped_pending = ped_pending_q;

endmodule
